deferred_control: RTL and testbench



---
 rtl/deferred_control.sv | 99 +++++++++
 tb/tb_deferred_control.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deferred_control.sv
// Batches per-cycle difftest step counts into one checker request every
// FETCH_INTERVAL cycles and turns the checker's verdict into a result code.
module deferred_control #(
   parameter int STEP_WIDTH     = 8,
   parameter int ACC_WIDTH      = 32,
   parameter int FETCH_INTERVAL = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [STEP_WIDTH-1:0] step,
   output logic [7:0]            simv_result,
   output logic                  req_valid,
   output logic [ACC_WIDTH-1:0]  req_nstep,
   input  logic                  req_ready,
   input  logic                  rsp_valid,
   input  logic [7:0]            rsp_code
);

   localparam int TIMER_W = $clog2(FETCH_INTERVAL);
   localparam int SUM_W   = ACC_WIDTH + 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FETCH_INTERVAL - 1);
   localparam logic [7:0] RES_RUN  = 8'd0;
   localparam logic [7:0] RES_DONE = 8'd1;
   localparam logic [7:0] RES_FAIL = 8'd2;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, FAILED} state_t;

   state_t               state;
   logic [TIMER_W-1:0]   timer;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] acc_next;
   logic                 tick;

   // Unsigned add that pins at all-ones instead of wrapping.
   function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [STEP_WIDTH-1:0] b);
      logic [SUM_W-1:0] sum;
      sum = {1'b0, a} + SUM_W'(b);
      return sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
   endfunction

   always_comb begin
      acc_next = sat_add(acc, step);
      tick     = (timer == TIMER_LAST);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= '0;
         acc         <= '0;
         req_valid   <= 1'b0;
         req_nstep   <= '0;
         simv_result <= RES_RUN;
      end else begin
         // DONE is a one-cycle pulse; a new verdict below may override this.
         if (simv_result == RES_DONE)
            simv_result <= RES_RUN;
         if (state != FAILED)
            timer <= tick ? '0 : timer + TIMER_W'(1);

         unique case (state)
            IDLE: begin
               if (tick && (acc_next != '0)) begin
                  req_nstep <= acc_next;
                  acc       <= '0;
                  req_valid <= 1'b1;
                  state     <= REQ;
               end else begin
                  acc <= acc_next;
               end
            end
            REQ: begin
               acc <= acc_next;
               if (req_ready) begin
                  req_valid <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               acc <= acc_next;
               if (rsp_valid) begin
                  if (rsp_code == RES_RUN) begin
                     state <= IDLE;
                  end else if (rsp_code == RES_DONE) begin
                     simv_result <= RES_DONE;
                     state       <= IDLE;
                  end else begin
                     simv_result <= RES_FAIL;
                     state       <= FAILED;
                  end
               end
            end
            default: ;  // FAILED: everything frozen until reset
         endcase
      end
   end

endmodule

// File: tb/tb_deferred_control.sv
// Bench for deferred_control: lockstep reference model on a default build plus
// a vector table and hand sequences on a narrow-accumulator build.
module tb_deferred_control;

   localparam int FI  = 16;
   localparam int AW  = 32;
   localparam int FI2 = 4;
   localparam int AW2 = 8;
   localparam longint unsigned MAXV = (64'd1 << AW) - 1;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset, req_ready, rsp_valid, req_valid;
   logic [7:0]    step, rsp_code, simv_result;
   logic [AW-1:0] req_nstep;

   logic           reset2, ready2, rv2, valid2;
   logic [7:0]     step2, code2, res2;
   logic [AW2-1:0] nstep2;

   deferred_control #(.STEP_WIDTH(8), .ACC_WIDTH(AW), .FETCH_INTERVAL(FI)) dut (
      .clock(clock), .reset(reset), .step(step), .simv_result(simv_result),
      .req_valid(req_valid), .req_nstep(req_nstep), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_code(rsp_code));

   deferred_control #(.STEP_WIDTH(8), .ACC_WIDTH(AW2), .FETCH_INTERVAL(FI2)) dut2 (
      .clock(clock), .reset(reset2), .step(step2), .simv_result(res2),
      .req_valid(valid2), .req_nstep(nstep2), .req_ready(ready2),
      .rsp_valid(rv2), .rsp_code(code2));

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: pending steps, cycle position in the interval, and
   // whether a batch is presented, awaiting a verdict, or the run has failed.
   longint unsigned m_acc, m_nstep;
   int              m_cnt, wait_age;
   bit              m_pending, m_waiting, m_failed;
   logic [7:0]      m_result;

   task automatic model_reset();
      m_acc = 0; m_nstep = 0; m_cnt = 0; wait_age = 0;
      m_pending = 0; m_waiting = 0; m_failed = 0; m_result = 0;
   endtask

   task automatic model_cycle(input int st, input bit rdy, input bit rv, input logic [7:0] code);
      longint unsigned sum;
      bit              on_tick;
      if (m_failed) return;
      sum = m_acc + longint'(st);
      if (sum > MAXV) sum = MAXV;
      on_tick = (m_cnt == FI - 1);
      m_cnt   = (m_cnt + 1) % FI;
      if (m_result == 8'd1) m_result = 0;
      if (m_pending) begin
         m_acc = sum;
         if (rdy) begin m_pending = 0; m_waiting = 1; end
      end else if (m_waiting) begin
         m_acc = sum;
         if (rv) begin
            m_waiting = 0;
            if (code == 8'd1) m_result = 8'd1;
            else if (code != 8'd0) begin m_result = 8'd2; m_failed = 1; end
         end
      end else if (on_tick && sum != 0) begin
         m_nstep = sum; m_acc = 0; m_pending = 1;
      end else begin
         m_acc = sum;
      end
   endtask

   task automatic main_cycle(input int st, input bit rdy, input bit rv, input logic [7:0] code);
      @(negedge clock);
      step = st[7:0]; req_ready = rdy; rsp_valid = rv; rsp_code = code;
      model_cycle(st, rdy, rv, code);
      @(posedge clock); #1;
      check("req_valid", 64'(req_valid), 64'(m_pending));
      check("req_nstep", 64'(req_nstep), m_nstep & MAXV);
      check("simv_result", 64'(simv_result), 64'(m_result));
   endtask

   // Checker stand-in: answers `delay` cycles into WAIT; optional stray rsp_valid.
   task automatic auto_cycle(input int st, input bit rdy, input logic [7:0] code,
                             input int delay, input bit noise);
      bit rv;
      logic [7:0] c;
      rv = m_waiting && (wait_age >= delay);
      c  = code;
      if (!m_waiting && noise && $urandom_range(0, 5) == 0) begin
         rv = 1'b1;
         c  = 8'($urandom_range(0, 255));
      end
      main_cycle(st, rdy, rv, c);
      wait_age = m_waiting ? wait_age + 1 : 0;
   endtask

   task automatic main_reset();
      @(negedge clock);
      reset = 1'b1; step = 0; req_ready = 0; rsp_valid = 0; rsp_code = 0;
      @(posedge clock); #1;
      model_reset();
      check("rst_req_valid", 64'(req_valid), 64'd0);
      check("rst_req_nstep", 64'(req_nstep), 64'd0);
      check("rst_simv_result", 64'(simv_result), 64'd0);
      reset = 1'b0;
   endtask

   typedef struct {
      logic [7:0] st; bit rdy; bit rv; logic [7:0] code;
      bit e_valid; logic [7:0] e_nstep; logic [7:0] e_res;
   } vec_t;
   vec_t tbl[16];

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      bit prev_valid, seen_first;
      int first_cycle, pulses, prev_batches;
      reset = 1; reset2 = 1;
      step = 0; req_ready = 0; rsp_valid = 0; rsp_code = 0;
      step2 = 0; ready2 = 0; rv2 = 0; code2 = 0;

      tbl[0]  = '{8'd0,   1, 0, 8'd0,   0, 8'd0,   8'd0};
      tbl[1]  = '{8'd255, 0, 0, 8'd0,   0, 8'd0,   8'd0};
      tbl[2]  = '{8'd255, 0, 0, 8'd0,   0, 8'd0,   8'd0};
      tbl[3]  = '{8'd255, 0, 0, 8'd0,   1, 8'd255, 8'd0};
      tbl[4]  = '{8'd10,  0, 0, 8'd0,   1, 8'd255, 8'd0};
      tbl[5]  = '{8'd10,  1, 0, 8'd0,   0, 8'd255, 8'd0};
      tbl[6]  = '{8'd5,   0, 1, 8'd1,   0, 8'd255, 8'd1};
      tbl[7]  = '{8'd0,   0, 0, 8'd0,   1, 8'd25,  8'd0};
      tbl[8]  = '{8'd3,   1, 0, 8'd0,   0, 8'd25,  8'd0};
      tbl[9]  = '{8'd1,   0, 1, 8'd0,   0, 8'd25,  8'd0};
      tbl[10] = '{8'd0,   0, 1, 8'd2,   0, 8'd25,  8'd0};
      tbl[11] = '{8'd0,   0, 0, 8'd0,   1, 8'd4,   8'd0};
      tbl[12] = '{8'd7,   1, 0, 8'd0,   0, 8'd4,   8'd0};
      tbl[13] = '{8'd1,   0, 1, 8'h7F,  0, 8'd4,   8'd2};
      tbl[14] = '{8'd9,   1, 1, 8'd0,   0, 8'd4,   8'd2};
      tbl[15] = '{8'd9,   0, 0, 8'd0,   0, 8'd4,   8'd2};

      repeat (2) @(posedge clock);
      main_reset();

      // Idle steps: no request ever.
      for (int i = 0; i < 3 * FI; i++) auto_cycle(0, 1, 0, 1, 0);

      // One step per cycle, prompt responses: 16 per batch.
      main_reset();
      prev_valid = 0; seen_first = 0; first_cycle = -1;
      for (int i = 0; i < 6 * FI; i++) begin
         auto_cycle(1, 1, 0, 1, 0);
         if (req_valid && !prev_valid) begin
            check("batch_nstep", 64'(req_nstep), 64'd16);
            if (!seen_first) begin seen_first = 1; first_cycle = i; end
         end
         prev_valid = req_valid;
      end
      check("first_req_seen", 64'(seen_first), 64'd1);
      check("first_req_cycle", 64'(first_cycle), 64'(FI - 1));

      // Back-pressure: hold the request for 40 cycles.
      main_reset();
      for (int i = 0; i < 2 * FI && !m_pending; i++) auto_cycle(2, 1, 0, 1, 0);
      check("bp_req_up", 64'(req_valid), 64'd1);
      for (int i = 0; i < 40; i++) begin
         auto_cycle(2, 0, 0, 1, 1);
         check("bp_nstep_hold", 64'(req_nstep), 64'd32);
      end
      for (int i = 0; i < 3 * FI; i++) auto_cycle(2, 1, 0, 2, 0);

      // DONE verdicts: one-cycle pulses, batching keeps going.
      pulses = 0;
      for (int i = 0; i < 4 * FI; i++) begin
         auto_cycle(3, 1, 1, 1, 0);
         if (simv_result == 8'd1) pulses++;
      end
      check("done_pulses", 64'(pulses), 64'd4);

      // Randomized traffic with stray responses and random back-pressure.
      for (int i = 0; i < 800; i++)
         auto_cycle(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0,
                    int'($urandom_range(0, 4)), 1);

      // Fail codes are sticky and stop batching; reset recovers.
      prev_batches = 0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4 * FI && !m_failed; i++)
            auto_cycle(5, 1, (k == 0) ? 8'd2 : 8'h7F, 1, 0);
         check("fail_code", 64'(simv_result), 64'd2);
         for (int i = 0; i < 40; i++) main_cycle(5, 1, 1, 8'd0);
         main_reset();
         for (int i = 0; i < 2 * FI; i++) auto_cycle(1, 0, 0, 1, 0);
         check("restart_req", 64'(req_valid), 64'd1);
      end

      // Narrow-accumulator build: vector table then reset corner cases.
      @(negedge clock); reset2 = 1;
      @(posedge clock); #1; reset2 = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         step2 = tbl[i].st; ready2 = tbl[i].rdy; rv2 = tbl[i].rv; code2 = tbl[i].code;
         @(posedge clock); #1;
         check($sformatf("tbl%0d_valid", i), 64'(valid2), 64'(tbl[i].e_valid));
         check($sformatf("tbl%0d_nstep", i), 64'(nstep2), 64'(tbl[i].e_nstep));
         check($sformatf("tbl%0d_result", i), 64'(res2), 64'(tbl[i].e_res));
      end
      @(negedge clock); reset2 = 1; step2 = 0; ready2 = 0; rv2 = 0; code2 = 0;
      @(posedge clock); #1; reset2 = 0;
      check("n_rst_result", 64'(res2), 64'd0);
      for (int i = 0; i < FI2; i++) begin
         @(negedge clock); step2 = 8'd100;
         @(posedge clock); #1;
      end
      check("n_sat_valid", 64'(valid2), 64'd1);
      check("n_sat_nstep", 64'(nstep2), 64'd255);
      @(negedge clock); reset2 = 1; ready2 = 1;
      @(posedge clock); #1;
      check("n_rst_req_valid", 64'(valid2), 64'd0);
      check("n_rst_req_nstep", 64'(nstep2), 64'd0);
      reset2 = 0; ready2 = 0; step2 = 0;
      for (int i = 0; i < FI2 + 1; i++) begin
         @(negedge clock); step2 = 0;
         @(posedge clock); #1;
      end
      check("n_post_rst_idle", 64'(valid2), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
